video_ram_arbiter: RTL and testbench
====================================

VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 Parameter LINE_BYTES, default 80, bytes fetched per display line (1..127).
REQ-002 Parameter ADDR_W, default 15, video RAM address width.
REQ-003 Parameter BASE_ADDR, default 0, RAM address of the first byte of line 0.
REQ-004 PIXELCLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 nRESET  in  1  reset; asynchronous, active-low.
REQ-006 ENDofLINE  in  1  one-cycle pulse from the timing generator; start of next line's fetch.
REQ-007 NEWSCREEN  in  1  one-cycle pulse; frame start; coincides with an ENDofLINE.
REQ-008 CPU_REQ  in  1  CPU access request; held high until CPU_ACK.
REQ-009 CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ high.
REQ-010 CPU_ADDR  in  ADDR_W  CPU byte address.
REQ-011 CPU_WDATA  in  8  CPU write data.
REQ-012 CPU_ACK  out  1  one-cycle completion pulse.
REQ-013 CPU_RDATA  out  8  read data, valid while CPU_ACK high for a read.
REQ-014 RAM_ADDR  out  ADDR_W  single-port RAM address.
REQ-015 RAM_WE  out  1  RAM write strobe.
REQ-016 RAM_WDATA  out  8  RAM write data.
REQ-017 RAM_RDATA  in  8  RAM read data, valid the cycle after RAM_ADDR is presented.
REQ-018 FETCH_WE  out  1  line-buffer write strobe.
REQ-019 FETCH_IDX  out  7  line-buffer byte index.
REQ-020 FETCH_DATA  out  8  line-buffer write data (RAM_RDATA forwarded).
REQ-021 FETCH_BANK  out  1  line-buffer half being filled; display reads the other half.
REQ-022 OVERRUN  out  1  sticky flag: ENDofLINE arrived while a fetch was still active.

Function
REQ-023 FSM states IDLE, CPU_RD, CPU_WAIT, CPU_WR, FETCH; reset state IDLE.
REQ-024 ENDofLINE sets fetch_pending, toggles FETCH_BANK, loads fetch index 0.
REQ-025 Priority: fetch_pending over CPU_REQ; CPU accepted only in IDLE with no fetch pending.
REQ-026 IDLE -> FETCH when fetch_pending; FETCH issues RAM_ADDR = line_addr + i for i = 0..LINE_BYTES-1, one per cycle, RAM_WE 0.
REQ-027 FETCH_WE high the cycle after each fetch address, with FETCH_IDX = i and FETCH_DATA = RAM_RDATA; last write ends FETCH -> IDLE.
REQ-028 On fetch completion line_addr += LINE_BYTES, modulo 2^ADDR_W (wrap, no saturation).
REQ-029 NEWSCREEN sets line_addr = BASE_ADDR before the fetch it triggers; frame's first fetch reads from BASE_ADDR.
REQ-030 Read: accept cycle N (IDLE->CPU_RD, RAM_ADDR = CPU_ADDR); N+1 CPU_WAIT captures RAM_RDATA; CPU_ACK high in N+2 with CPU_RDATA; -> IDLE.
REQ-031 Write: accept cycle N (IDLE->CPU_WR, RAM_ADDR/RAM_WDATA/RAM_WE = 1); CPU_ACK high in N+1; -> IDLE.
REQ-032 No new CPU request accepted in the cycle CPU_ACK is high.
REQ-033 ENDofLINE during a CPU access: access completes unchanged; FETCH entered in the cycle after the access returns to IDLE.
REQ-034 ENDofLINE during FETCH: OVERRUN set, current fetch abandoned without line_addr advance, new fetch restarts at index 0 on next cycle.
REQ-035 CPU wait bounded at LINE_BYTES + 3 cycles when ENDofLINE spacing exceeds LINE_BYTES + 3.
REQ-036 RAM_WE high only in CPU_WR; RAM_ADDR/RAM_WDATA hold last value otherwise.

Reset
REQ-037 nRESET low asynchronously clears: state IDLE, fetch_pending 0, line_addr BASE_ADDR, index 0, FETCH_BANK 0, OVERRUN 0.
REQ-038 All outputs 0 during reset; CPU access or fetch in flight is dropped without CPU_ACK.
REQ-039 OVERRUN cleared only by reset.

Structure
REQ-040 Shared package vga_pkg holds the FSM state enum, default LINE_BYTES, ADDR_W.
REQ-041 One sub-module, line_addr_gen: line_addr register with NEWSCREEN load and LINE_BYTES advance.

Verification
REQ-042 ENDofLINE, no CPU traffic, BASE_ADDR 0 -> RAM_ADDR 0..79 consecutive, FETCH_WE 80 cycles with FETCH_IDX 0..79, FETCH_BANK toggled.
REQ-043 Three ENDofLINE then NEWSCREEN+ENDofLINE -> fetches start at 0, 80, 160, then 0.
REQ-044 CPU write 0xA5 to 0x1234 while idle -> RAM_WE one cycle at 0x1234, CPU_ACK next cycle; read back -> CPU_ACK 2 cycles after accept, CPU_RDATA 0xA5.
REQ-045 CPU_REQ and ENDofLINE same cycle -> fetch runs first, CPU_ACK arrives 83 cycles later for a read.
REQ-046 line_addr 0x7FD0 with LINE_BYTES 80 -> fetch addresses wrap 0x7FFF to 0x0000, next line_addr 0x0020.
REQ-047 Second ENDofLINE 40 cycles into a fetch -> OVERRUN 1, fetch restarts at index 0; nRESET low mid-fetch -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the video RAM arbiter: FSM states and default geometry.
package vga_pkg;

  localparam int LINE_BYTES_DEF = 80;
  localparam int ADDR_W_DEF     = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_RD   = 3'd1,
    CPU_WAIT = 3'd2,
    CPU_WR   = 3'd3,
    FETCH    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/video_ram_arbiter_line_addr_gen.sv
// Line start address generator: reloads the frame base on NEWSCREEN and
// steps one line forward when a fetch completes (wraps at 2^ADDR_W).
module line_addr_gen
  import vga_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BASE_ADDR  = 0
) (
  input  logic              PIXELCLK,
  input  logic              nRESET,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LINE_BYTES);

  logic [ADDR_W-1:0] line_addr;

  // A fetch triggered in the same cycle as NEWSCREEN must already start at the base.
  assign start_addr = load ? BASE : line_addr;

  // Line address register: base reload has priority over the per-line advance.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) begin
      line_addr <= BASE;
    end else if (load) begin
      line_addr <= BASE;
    end else if (advance) begin
      line_addr <= line_addr + STEP;
    end
  end

endmodule

// File: rtl/video_ram_arbiter.sv
// Single-port video RAM arbiter: line-buffer fetches take priority over CPU
// byte accesses; a late ENDofLINE abandons the running fetch and flags OVERRUN.
module video_ram_arbiter
  import vga_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BASE_ADDR  = 0
) (
  input  logic              PIXELCLK,
  input  logic              nRESET,
  input  logic              ENDofLINE,
  input  logic              NEWSCREEN,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic              CPU_ACK,
  output logic [7:0]        CPU_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [7:0]        RAM_WDATA,
  input  logic [7:0]        RAM_RDATA,
  output logic              FETCH_WE,
  output logic [6:0]        FETCH_IDX,
  output logic [7:0]        FETCH_DATA,
  output logic              FETCH_BANK,
  output logic              OVERRUN
);

  localparam logic [6:0] LAST_IDX = 7'(LINE_BYTES - 1);

  arb_state_t        state, state_nxt;
  logic              fetch_pending;
  logic [6:0]        idx;
  logic [ADDR_W-1:0] start_addr;
  logic              pend, cpu_ok, last_issue, advance;
  logic              start_fetch, start_cpu;

  // A line-start pulse blocks the CPU in the very cycle it arrives, not one later.
  assign pend        = fetch_pending | ENDofLINE;
  assign cpu_ok      = CPU_REQ & ~CPU_ACK & ~pend;
  assign last_issue  = (state == FETCH) && (idx == LAST_IDX);
  assign advance     = last_issue & ~ENDofLINE;
  assign start_fetch = (state_nxt == FETCH) && ((state != FETCH) || ENDofLINE);
  assign start_cpu   = (state_nxt == CPU_RD) || (state_nxt == CPU_WR);
  assign FETCH_DATA  = FETCH_WE ? RAM_RDATA : 8'h00;

  line_addr_gen #(
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_line_addr_gen (
    .PIXELCLK   (PIXELCLK),
    .nRESET     (nRESET),
    .load       (NEWSCREEN),
    .advance    (advance),
    .start_addr (start_addr)
  );

  // State register.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: fetch beats CPU; the last fetch address hands straight to a waiting CPU.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pend)        state_nxt = FETCH;
        else if (cpu_ok) state_nxt = CPU_WE ? CPU_WR : CPU_RD;
      end
      CPU_RD:   state_nxt = CPU_WAIT;
      CPU_WAIT: state_nxt = IDLE;
      CPU_WR:   state_nxt = IDLE;
      FETCH: begin
        if (ENDofLINE)       state_nxt = FETCH;
        else if (last_issue) state_nxt = cpu_ok ? (CPU_WE ? CPU_WR : CPU_RD) : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Control flags: pending fetch, buffer bank, sticky overrun, CPU handshake.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) begin
      fetch_pending <= 1'b0;
      FETCH_BANK    <= 1'b0;
      OVERRUN       <= 1'b0;
      CPU_ACK       <= 1'b0;
      CPU_RDATA     <= 8'h00;
    end else begin
      fetch_pending <= pend && (state_nxt != FETCH);
      if (ENDofLINE) FETCH_BANK <= ~FETCH_BANK;
      if (ENDofLINE && (state == FETCH)) OVERRUN <= 1'b1;
      CPU_ACK <= (state == CPU_WAIT) || (state == CPU_WR);
      if (state == CPU_WAIT) CPU_RDATA <= RAM_RDATA;
    end
  end

  // RAM port and fetch address sequencing; address/data hold when unused.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) begin
      RAM_ADDR  <= '0;
      RAM_WE    <= 1'b0;
      RAM_WDATA <= 8'h00;
      idx       <= 7'd0;
    end else begin
      RAM_WE <= 1'b0;
      if (start_fetch) begin
        RAM_ADDR <= start_addr;
        idx      <= 7'd0;
      end else if ((state == FETCH) && (state_nxt == FETCH)) begin
        RAM_ADDR <= RAM_ADDR + ADDR_W'(1);
        idx      <= idx + 7'd1;
      end else if (start_cpu) begin
        RAM_ADDR <= CPU_ADDR;
        RAM_WE   <= CPU_WE;
        if (CPU_WE) RAM_WDATA <= CPU_WDATA;
      end
    end
  end

  // Line-buffer write trails each fetch address by one cycle; an abandoned
  // fetch's in-flight byte is dropped.
  always_ff @(posedge PIXELCLK or negedge nRESET) begin
    if (!nRESET) begin
      FETCH_WE  <= 1'b0;
      FETCH_IDX <= 7'd0;
    end else begin
      FETCH_WE  <= (state == FETCH) && !ENDofLINE;
      FETCH_IDX <= idx;
    end
  end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Directed bench for video_ram_arbiter with a small behavioural RAM model.
module tb_video_ram_arbiter;

  logic        PIXELCLK;
  logic        nRESET;
  logic        ENDofLINE;
  logic        NEWSCREEN;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [14:0] CPU_ADDR;
  logic [7:0]  CPU_WDATA;
  logic        CPU_ACK;
  logic [7:0]  CPU_RDATA;
  logic [14:0] RAM_ADDR;
  logic        RAM_WE;
  logic [7:0]  RAM_WDATA;
  logic [7:0]  RAM_RDATA;
  logic        FETCH_WE;
  logic [6:0]  FETCH_IDX;
  logic [7:0]  FETCH_DATA;
  logic        FETCH_BANK;
  logic        OVERRUN;

  int tests = 0;
  int fails = 0;

  logic        wr_valid = 1'b0;
  logic [14:0] wr_addr  = '0;
  logic [7:0]  wr_data  = '0;

  video_ram_arbiter dut (
    .PIXELCLK   (PIXELCLK),
    .nRESET     (nRESET),
    .ENDofLINE  (ENDofLINE),
    .NEWSCREEN  (NEWSCREEN),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_ACK    (CPU_ACK),
    .CPU_RDATA  (CPU_RDATA),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WE     (RAM_WE),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_RDATA  (RAM_RDATA),
    .FETCH_WE   (FETCH_WE),
    .FETCH_IDX  (FETCH_IDX),
    .FETCH_DATA (FETCH_DATA),
    .FETCH_BANK (FETCH_BANK),
    .OVERRUN    (OVERRUN)
  );

  initial PIXELCLK = 1'b0;
  always #5 PIXELCLK = ~PIXELCLK;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  // RAM model: one-cycle read latency, remembers the last byte written.
  always @(posedge PIXELCLK) begin
    if (RAM_WE) begin
      wr_valid <= 1'b1;
      wr_addr  <= RAM_ADDR;
      wr_data  <= RAM_WDATA;
    end
    RAM_RDATA <= (wr_valid && (wr_addr == RAM_ADDR)) ? wr_data : pat(RAM_ADDR);
  end

  task automatic tick();
    @(posedge PIXELCLK);
    #1;
  endtask

  task automatic do_reset();
    nRESET = 1'b0; ENDofLINE = 1'b0; NEWSCREEN = 1'b0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    tick(); tick();
    nRESET = 1'b1;
    tick();
  endtask

  task automatic pulse_eol(input logic ns);
    NEWSCREEN = ns; ENDofLINE = 1'b1;
    tick();
    NEWSCREEN = 1'b0; ENDofLINE = 1'b0;
  endtask

  task automatic test_reset();
    logic [50:0] outs;
    nRESET = 1'b0; ENDofLINE = 1'b0; NEWSCREEN = 1'b0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    #1;
    outs = {CPU_ACK, CPU_RDATA, RAM_ADDR, RAM_WE, RAM_WDATA, FETCH_WE, FETCH_IDX,
            FETCH_DATA, FETCH_BANK, OVERRUN};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    tick(); tick();
    nRESET = 1'b1;
    tick(); tick();
    outs = {CPU_ACK, CPU_RDATA, RAM_ADDR, RAM_WE, RAM_WDATA, FETCH_WE, FETCH_IDX,
            FETCH_DATA, FETCH_BANK, OVERRUN};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_fetch_line();
    logic bank0;
    bank0 = FETCH_BANK;
    pulse_eol(1'b0);
    tests++;
    if (FETCH_BANK !== ~bank0) begin
      fails++; $display("FAIL fetch_bank: got %b expected %b", FETCH_BANK, ~bank0);
    end
    for (int i = 0; i <= 80; i++) begin
      if (i < 80) begin
        tests++;
        if (RAM_ADDR !== 15'(i) || RAM_WE !== 1'b0) begin
          fails++; $display("FAIL fetch_addr[%0d]: got %h we %b expected %h we 0", i, RAM_ADDR, RAM_WE, 15'(i));
        end
      end
      tests++;
      if (i == 0) begin
        if (FETCH_WE !== 1'b0) begin
          fails++; $display("FAIL fetch_we_first: got %b expected 0", FETCH_WE);
        end
      end else if (FETCH_WE !== 1'b1 || FETCH_IDX !== 7'(i-1) || FETCH_DATA !== pat(15'(i-1))) begin
        fails++; $display("FAIL fetch_write[%0d]: got we %b idx %0d data %h expected we 1 idx %0d data %h",
                          i-1, FETCH_WE, FETCH_IDX, FETCH_DATA, i-1, pat(15'(i-1)));
      end
      tick();
    end
    tests++;
    if (FETCH_WE !== 1'b0) begin
      fails++; $display("FAIL fetch_we_end: got %b expected 0", FETCH_WE);
    end
  endtask

  task automatic test_line_sequence();
    logic [14:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pulse_eol(k == 3);
      exp = (k == 3) ? 15'd0 : 15'(80 * k);
      tests++;
      if (RAM_ADDR !== exp) begin
        fails++; $display("FAIL line_start[%0d]: got %h expected %h", k, RAM_ADDR, exp);
      end
      repeat (84) tick();
    end
    tests++;
    if (FETCH_BANK !== 1'b0) begin
      fails++; $display("FAIL bank_after_four: got %b expected 0", FETCH_BANK);
    end
  endtask

  task automatic test_cpu_rw();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h1234; CPU_WDATA = 8'hA5;
    tick();
    tests++;
    if (RAM_WE !== 1'b1 || RAM_ADDR !== 15'h1234 || RAM_WDATA !== 8'hA5 || CPU_ACK !== 1'b0) begin
      fails++; $display("FAIL cpu_wr_issue: got we %b addr %h data %h ack %b expected 1 1234 a5 0",
                        RAM_WE, RAM_ADDR, RAM_WDATA, CPU_ACK);
    end
    tick();
    tests++;
    if (CPU_ACK !== 1'b1 || RAM_WE !== 1'b0) begin
      fails++; $display("FAIL cpu_wr_ack: got ack %b we %b expected ack 1 we 0", CPU_ACK, RAM_WE);
    end
    tick();
    tests++;
    if (CPU_ACK !== 1'b0 || RAM_WE !== 1'b0) begin
      fails++; $display("FAIL cpu_no_reaccept: got ack %b we %b expected 0 0", CPU_ACK, RAM_WE);
    end
    CPU_REQ = 1'b0;
    tick();
    CPU_REQ = 1'b1; CPU_WE = 1'b0;
    tick();
    tests++;
    if (RAM_ADDR !== 15'h1234 || RAM_WE !== 1'b0 || CPU_ACK !== 1'b0) begin
      fails++; $display("FAIL cpu_rd_issue: got addr %h we %b ack %b expected 1234 0 0", RAM_ADDR, RAM_WE, CPU_ACK);
    end
    tick();
    tests++;
    if (CPU_ACK !== 1'b0) begin
      fails++; $display("FAIL cpu_rd_wait: got ack %b expected 0", CPU_ACK);
    end
    tick();
    tests++;
    if (CPU_ACK !== 1'b1 || CPU_RDATA !== 8'hA5) begin
      fails++; $display("FAIL cpu_rd_ack: got ack %b data %h expected 1 a5", CPU_ACK, CPU_RDATA);
    end
    CPU_REQ = 1'b0;
    tick();
    tests++;
    if (CPU_ACK !== 1'b0) begin
      fails++; $display("FAIL cpu_ack_pulse: got %b expected 0", CPU_ACK);
    end
  endtask

  task automatic test_collision();
    int n;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h1234;
    pulse_eol(1'b0);
    tests++;
    if (RAM_ADDR !== 15'd80 || RAM_WE !== 1'b0) begin
      fails++; $display("FAIL collide_fetch_first: got addr %h we %b expected 0050 0", RAM_ADDR, RAM_WE);
    end
    n = 1;
    while (CPU_ACK !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n != 83 || CPU_RDATA !== 8'hA5) begin
      fails++; $display("FAIL collide_ack_latency: got %0d cycles data %h expected 83 a5", n, CPU_RDATA);
    end
    CPU_REQ = 1'b0;
    tick();
  endtask

  task automatic test_eol_during_cpu();
    logic bank0;
    bank0 = FETCH_BANK;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h1234;
    tick();
    pulse_eol(1'b0);
    tests++;
    if (FETCH_BANK !== ~bank0 || CPU_ACK !== 1'b0 || RAM_ADDR !== 15'h1234) begin
      fails++; $display("FAIL eol_cpu_hold: got bank %b ack %b addr %h expected %b 0 1234",
                        FETCH_BANK, CPU_ACK, RAM_ADDR, ~bank0);
    end
    tick();
    tests++;
    if (CPU_ACK !== 1'b1 || CPU_RDATA !== 8'hA5) begin
      fails++; $display("FAIL eol_cpu_ack: got ack %b data %h expected 1 a5", CPU_ACK, CPU_RDATA);
    end
    CPU_REQ = 1'b0;
    tick();
    tests++;
    if (RAM_ADDR !== 15'd160) begin
      fails++; $display("FAIL eol_cpu_fetch_start: got %h expected 00a0", RAM_ADDR);
    end
    repeat (84) tick();
  endtask

  task automatic test_overrun();
    logic [50:0] outs;
    do_reset();
    tests++;
    if (OVERRUN !== 1'b0) begin
      fails++; $display("FAIL overrun_init: got %b expected 0", OVERRUN);
    end
    pulse_eol(1'b0);
    repeat (39) tick();
    tests++;
    if (RAM_ADDR !== 15'd39 || OVERRUN !== 1'b0) begin
      fails++; $display("FAIL overrun_mid: got addr %h ovr %b expected 0027 0", RAM_ADDR, OVERRUN);
    end
    pulse_eol(1'b0);
    tests++;
    if (OVERRUN !== 1'b1 || RAM_ADDR !== 15'd0 || FETCH_WE !== 1'b0) begin
      fails++; $display("FAIL overrun_restart: got ovr %b addr %h we %b expected 1 0000 0", OVERRUN, RAM_ADDR, FETCH_WE);
    end
    tick();
    tests++;
    if (FETCH_WE !== 1'b1 || FETCH_IDX !== 7'd0 || RAM_ADDR !== 15'd1) begin
      fails++; $display("FAIL overrun_idx0: got we %b idx %0d addr %h expected 1 0 0001", FETCH_WE, FETCH_IDX, RAM_ADDR);
    end
    repeat (84) tick();
    tests++;
    if (OVERRUN !== 1'b1) begin
      fails++; $display("FAIL overrun_sticky: got %b expected 1", OVERRUN);
    end
    pulse_eol(1'b0);
    tests++;
    if (RAM_ADDR !== 15'd80) begin
      fails++; $display("FAIL overrun_single_advance: got %h expected 0050", RAM_ADDR);
    end
    repeat (10) tick();
    nRESET = 1'b0;
    #1;
    outs = {CPU_ACK, CPU_RDATA, RAM_ADDR, RAM_WE, RAM_WDATA, FETCH_WE, FETCH_IDX,
            FETCH_DATA, FETCH_BANK, OVERRUN};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_mid_fetch: got %h expected 0", outs);
    end
    tick();
    nRESET = 1'b1;
    repeat (3) tick();
    tests++;
    if (FETCH_WE !== 1'b0 || RAM_ADDR !== 15'd0 || CPU_ACK !== 1'b0) begin
      fails++; $display("FAIL fetch_dropped: got we %b addr %h ack %b expected 0 0000 0", FETCH_WE, RAM_ADDR, CPU_ACK);
    end
  endtask

  task automatic test_wrap();
    logic [14:0] exp;
    do_reset();
    pulse_eol(1'b1);
    repeat (83) tick();
    for (int k = 1; k <= 408; k++) begin
      pulse_eol(1'b0);
      repeat (83) tick();
    end
    pulse_eol(1'b0);
    for (int i = 0; i < 80; i++) begin
      exp = 15'h7FD0 + 15'(i);
      tests++;
      if (RAM_ADDR !== exp) begin
        fails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, RAM_ADDR, exp);
      end
      tick();
    end
    repeat (5) tick();
    pulse_eol(1'b0);
    tests++;
    if (RAM_ADDR !== 15'h0020) begin
      fails++; $display("FAIL wrap_next_line: got %h expected 0020", RAM_ADDR);
    end
    repeat (84) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_line();
    test_line_sequence();
    test_cpu_rw();
    test_collision();
    test_eol_during_cpu();
    test_overrun();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
